// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the ALS sampling scheduler: FSM states, SPI
// control-word layout, register-select encodings and light-value bit window.
package spi_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_CTRL,
    S_POLL_A,
    S_POLL_C,
    S_RD0,
    S_RD0_C,
    S_RD1,
    S_RD1_C,
    S_CAPTURE,
    S_WAIT
  } sched_state_e;

  localparam int CTRL_SEND_BIT = 0;
  localparam int CTRL_ALL1_BIT = 1;
  localparam int CTRL_ALL0_BIT = 2;
  localparam int CTRL_NTX_LSB  = 4;
  localparam int CTRL_NTX_MSB  = 12;

  // n_tx_end counts from zero, so 1 means a two-byte transfer
  localparam logic [8:0] CTRL_NTX_END = 9'd1;

  function automatic logic [31:0] ctrl_word();
    logic [31:0] w;
    w = '0;
    w[CTRL_SEND_BIT] = 1'b1;
    w[CTRL_ALL1_BIT] = 1'b0;
    w[CTRL_ALL0_BIT] = 1'b1;
    w[CTRL_NTX_MSB:CTRL_NTX_LSB] = CTRL_NTX_END;
    return w;
  endfunction

  localparam logic [31:0] CTRL_WORD = ctrl_word();

  localparam logic REG_CTRL = 1'b0;
  localparam logic REG_DATA = 1'b1;

  localparam int ALS_MSB = 12;
  localparam int ALS_LSB = 5;

endpackage

// File: rtl/sched_tick_counter.sv
// Period counter: reloads when a sample sequence starts and saturates at the
// last cycle of the period, so an overlong sequence never wraps the count.
module sched_tick_counter #(
  parameter int PERIOD_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int            CW   = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // start is high during the WR_CTRL cycle, so that cycle counts as tick 0
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= CW'(1);
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done = (cnt_q == LAST);

endmodule

// File: rtl/spi_als_sample_sched.sv
// Periodic/one-shot sampling sequencer for the PMOD ALS behind the SPI
// register-interface controller; delivers an 8-bit light value with a strobe.
module spi_als_sample_sched
  import spi_sched_pkg::*;
#(
  parameter int PERIOD_CYCLES = 10_000_000,
  parameter int POLL_LIMIT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        single_i,
  output logic        reg_sel_o,
  output logic        wr_o,
  output logic [31:0] entrada_o,
  output logic [31:0] addr_o,
  input  logic [31:0] salida_i,
  output logic [7:0]  sample_o,
  output logic        sample_valid_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int            PW        = $clog2(POLL_LIMIT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

  sched_state_e  state_q;
  logic          enable_q;
  logic [PW-1:0] poll_cnt_q;
  logic [7:0]    hi_p0;
  logic          period_done;
  logic          start_req;
  logic          unused_salida;

  function automatic logic [7:0] als_extract(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] word;
    word = {hi, lo};
    return word[ALS_MSB:ALS_LSB];
  endfunction

  assign unused_salida = ^salida_i[31:8];

  sched_tick_counter #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .start(state_q == S_WR_CTRL),
    .done (period_done)
  );

  // From IDLE free-run starts on the enable edge; from WAIT it starts when the period expires
  assign start_req = single_i |
                     ((state_q == S_IDLE) ? (enable_i & ~enable_q)
                                          : (enable_i & period_done));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      enable_q       <= 1'b0;
      poll_cnt_q     <= '0;
      reg_sel_o      <= REG_CTRL;
      wr_o           <= 1'b0;
      entrada_o      <= '0;
      addr_o         <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      enable_q       <= enable_i;
      wr_o           <= 1'b0;
      entrada_o      <= '0;
      sample_valid_o <= 1'b0;
      case (state_q)
        S_IDLE, S_WAIT: begin
          if (start_req) begin
            state_q    <= S_WR_CTRL;
            wr_o       <= 1'b1;
            entrada_o  <= CTRL_WORD;
            reg_sel_o  <= REG_CTRL;
            addr_o     <= '0;
            busy_o     <= 1'b1;
            poll_cnt_q <= '0;
          end else if (state_q == S_WAIT && !enable_i) begin
            state_q <= S_IDLE;
          end
        end
        S_WR_CTRL: state_q <= S_POLL_A;
        S_POLL_A:  state_q <= S_POLL_C;
        S_POLL_C: begin
          if (!salida_i[CTRL_SEND_BIT]) begin
            state_q   <= S_RD0;
            reg_sel_o <= REG_DATA;
            addr_o    <= 32'd0;
          end else if (poll_cnt_q == POLL_LAST) begin
            state_q   <= S_WAIT;
            timeout_o <= 1'b1;
            busy_o    <= 1'b0;
          end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
            state_q    <= S_POLL_A;
          end
        end
        S_RD0: state_q <= S_RD0_C;
        S_RD0_C: begin
          state_q <= S_RD1;
          addr_o  <= 32'd1;
        end
        S_RD1: state_q <= S_RD1_C;
        S_RD1_C: begin
          state_q        <= S_CAPTURE;
          sample_o       <= als_extract(hi_p0, salida_i[7:0]);
          sample_valid_o <= 1'b1;
          timeout_o      <= 1'b0;
          reg_sel_o      <= REG_CTRL;
          addr_o         <= '0;
        end
        S_CAPTURE: begin
          state_q <= S_WAIT;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // Data path: high byte held until the low byte arrives
  always_ff @(posedge clk) begin
    if (state_q == S_RD0_C) begin
      hi_p0 <= salida_i[7:0];
    end
  end

endmodule
